// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master FSM states and parameter defaults.
package spi_pkg;
    localparam int MAX_PIXEL_BITS  = 8;
    localparam int CLK_DIV_DEFAULT = 2;
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} spi_state_e;
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: SPI master request/response handshake plus the four-wire serial bus.
interface spi_master_if import spi_pkg::*; #(parameter int WORD_SIZE = MAX_PIXEL_BITS);
    logic                 start_i;
    logic [WORD_SIZE-1:0] data_tx_i;
    logic [WORD_SIZE-1:0] data_rx_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 sck_o;
    logic                 cs_o;
    logic                 mosi_o;
    logic                 miso_i;
    modport master (input start_i, data_tx_i, miso_i,
                    output data_rx_o, busy_o, done_o, sck_o, cs_o, mosi_o);
    modport slave  (output start_i, data_tx_i, miso_i,
                    input data_rx_o, busy_o, done_o, sck_o, cs_o, mosi_o);
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV-cycle down-counter giving a one-cycle tick at the end of each half-period.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt;
    assign tick = (cnt == '0);
    always_ff @(posedge clk_i or negedge nreset_i)
        if (!nreset_i) cnt <= LOAD;
        else cnt <= (clr || tick) ? LOAD : cnt - CW'(1);
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one WORD_SIZE word per accepted start_i.
// Define SPI_MASTER_BURST_EN to chain back-to-back words inside one cs_o frame.
module spi_master import spi_pkg::*; #(
    parameter int WORD_SIZE = MAX_PIXEL_BITS,
    parameter int CLK_DIV   = CLK_DIV_DEFAULT
) (
    input logic          clk_i,
    input logic          nreset_i,
    spi_master_if.master bus
);
    localparam int BW = $clog2(WORD_SIZE);
    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_master: CLK_DIV must be >= 1");
    end
    if (WORD_SIZE < 2) begin : g_bad_word
        $error("spi_master: WORD_SIZE must be >= 2");
    end
    spi_state_e           state;
    logic [WORD_SIZE-1:0] sh_tx;
    logic [WORD_SIZE-1:0] sh_rx;
    logic [BW-1:0]        bit_cnt;
    logic                 tick;
    logic                 last;
    assign last        = (bit_cnt == BW'(WORD_SIZE - 1));
    assign bus.mosi_o  = sh_tx[WORD_SIZE-1];
    // Every other state change coincides with a tick, which reloads the counter anyway.
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .clr      (state == IDLE),
        .tick     (tick)
    );
    always_ff @(posedge clk_i or negedge nreset_i)
        if (!nreset_i) begin
            state         <= IDLE;
            sh_tx         <= '0;
            sh_rx         <= '0;
            bit_cnt       <= '0;
            bus.sck_o     <= 1'b0;
            bus.cs_o      <= 1'b1;
            bus.busy_o    <= 1'b0;
            bus.done_o    <= 1'b0;
            bus.data_rx_o <= '0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                IDLE: if (bus.start_i) begin
                    state      <= SETUP;
                    sh_tx      <= bus.data_tx_i;
                    bit_cnt    <= '0;
                    bus.cs_o   <= 1'b0;
                    bus.busy_o <= 1'b1;
                end
                SETUP: if (tick) begin
                    state     <= SCK_HI;
                    bus.sck_o <= 1'b1;
                    sh_rx     <= {sh_rx[WORD_SIZE-2:0], bus.miso_i};
                end
                SCK_HI: if (tick) begin
                    state     <= SCK_LO;
                    bus.sck_o <= 1'b0;
                    if (!last) sh_tx <= sh_tx << 1;
                end
                SCK_LO: if (tick) begin
                    if (!last) begin
                        state     <= SCK_HI;
                        bus.sck_o <= 1'b1;
                        bit_cnt   <= bit_cnt + BW'(1);
                        sh_rx     <= {sh_rx[WORD_SIZE-2:0], bus.miso_i};
                    end
`ifdef SPI_MASTER_BURST_EN
                    else if (bus.start_i) begin
                        state         <= SETUP;
                        sh_tx         <= bus.data_tx_i;
                        bit_cnt       <= '0;
                        bus.done_o    <= 1'b1;
                        bus.data_rx_o <= sh_rx;
                    end
`endif
                    else state <= HOLD;
                end
                HOLD: if (tick) begin
                    state         <= GAP;
                    sh_tx         <= '0;
                    bus.cs_o      <= 1'b1;
                    bus.done_o    <= 1'b1;
                    bus.data_rx_o <= sh_rx;
                end
                GAP: if (tick) begin
                    state      <= IDLE;
                    bus.busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
